spi_slave: RTL and testbench

- SPI responder (slave) for the peripheral side of the SPI link driven by the team's SPI master.
- Receives MSB-first bytes on mosi and returns MSB-first bytes on miso under an externally generated sclk/ss_n, in all four cpol/cpha modes.
- Oversamples the asynchronous SPI pins with the system clock, so sclk must be much slower than clk.
- Presents each received byte to fabric logic with a one-cycle done tick and supports back-to-back bytes within one ss_n frame.

---
 rtl/spi_slave.sv | 153 +++++++++++++++
 tb/tb_spi_slave.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI responder (slave), MSB-first, all four cpol/cpha modes.
//
// The SPI pins are asynchronous to clk. They are oversampled through
// SYNC_STAGES flip-flops, and sclk edges are found by comparing the
// synchronized sclk with a registered copy of it. For this to work, sclk must
// be much slower than clk: each half-period must be at least SYNC_STAGES+2
// clk cycles.
//
// Ports:
//   clk, reset      system clock; synchronous active-high reset
//   din   [DW-1:0]  byte to transmit; loaded at frame start and at each
//                   byte boundary
//   cpol, cpha      SPI mode; captured when ss_n falls
//   dout  [DW-1:0]  last complete received byte
//   spi_done_tick   one-cycle pulse per received byte
//   busy            frame active
//   sclk, ss_n, mosi  SPI pins from the master (asynchronous)
//   miso, miso_oe   serial data out and its tristate enable
module spi_slave #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] din,
  input  logic          cpol,
  input  logic          cpha,
  output logic [DW-1:0] dout,
  output logic          spi_done_tick,
  output logic          busy,
  input  logic          sclk,
  input  logic          ss_n,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_q, ss_q;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic                   lead_edge, trail_edge, sample_edge, shift_edge;
  logic                   byte_done, done_pend;
  logic                   cpol_r, cpha_r;
  logic [CW-1:0]          count;
  logic [DW-1:0]          rx, tx;

  // Synchronizers and the registered copies used for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      ss_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
      ss_q      <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign ss_fall   = ~ss_s & ss_q;
  assign ss_rise   = ss_s & ~ss_q;

  // The leading edge leaves the idle level; cpha chooses which edge samples
  assign lead_edge   = cpol_r ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_r ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_r ? trail_edge : lead_edge;
  assign shift_edge  = cpha_r ? lead_edge : trail_edge;
  assign byte_done   = (state == XFER) && sample_edge && (count == CW'(DW - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) state_next = XFER;
      end
      XFER: begin
        busy = 1'b1;
        if (ss_rise) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign miso_oe = busy;
  assign miso    = tx[DW-1];

  // Shift datapath; the tick is delayed one cycle behind the dout update
  always_ff @(posedge clk) begin
    if (reset) begin
      cpol_r        <= 1'b0;
      cpha_r        <= 1'b0;
      count         <= '0;
      rx            <= '0;
      tx            <= '0;
      dout          <= '0;
      done_pend     <= 1'b0;
      spi_done_tick <= 1'b0;
    end else begin
      done_pend     <= byte_done;
      spi_done_tick <= done_pend;
      if (state == IDLE) begin
        if (ss_fall) begin
          cpol_r <= cpol;
          cpha_r <= cpha;
          tx     <= din;
          count  <= '0;
        end
      end else begin
        if (sample_edge) begin
          rx <= {rx[DW-2:0], mosi_s};
          if (count == CW'(DW - 1)) begin
            dout  <= {rx[DW-2:0], mosi_s};
            count <= '0;
            tx    <= din;
          end else begin
            count <= count + CW'(1);
          end
        end else if (shift_edge && (count != '0)) begin
          // count==0 marks the first leading edge (cpha=1) or the trailing
          // edge just after a byte boundary (cpha=0): miso already holds
          // the new MSB and must not move
          tx <= {tx[DW-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Testbench for spi_slave: a bit-banged SPI master drives the pins with
// directed bytes in all four modes, and a per-cycle scoreboard predicts
// busy, miso_oe, spi_done_tick and dout from the pin history and from the
// bytes the master has completed.
module tb_spi_slave;

  localparam int DW = 8;
  localparam int S  = 2;   // SYNC_STAGES
  localparam int HP = 8;   // sclk half-period in clk cycles
  localparam int Q  = 4;   // mosi setup time before a cpha=0 leading edge
  localparam int HN = 16384;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] din;
  logic          cpol, cpha;
  logic [DW-1:0] dout;
  logic          spi_done_tick, busy;
  logic          sclk, ss_n, mosi;
  logic          miso, miso_oe;

  spi_slave #(.DW(DW), .SYNC_STAGES(S)) dut (
    .clk          (clk),
    .reset        (reset),
    .din          (din),
    .cpol         (cpol),
    .cpha         (cpha),
    .dout         (dout),
    .spi_done_tick(spi_done_tick),
    .busy         (busy),
    .sclk         (sclk),
    .ss_n         (ss_n),
    .mosi         (mosi),
    .miso         (miso),
    .miso_oe      (miso_oe)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_rst = 0;
  logic ss_hist [0:HN-1];
  logic m_pol, m_pha;
  logic [DW-1:0] exp_dout = '0;

  typedef struct {
    int            cyc;
    logic [DW-1:0] b;
  } exp_t;
  exp_t tq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard: busy follows the ss_n pin SYNC_STAGES edges late (never
  // reaching back across a reset); a tick is due SYNC_STAGES+2 cycles after
  // the pin-level final sample edge of each completed byte.
  initial begin
    logic exp_busy, exp_tick, tick_next;
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (cyc < HN) ss_hist[cyc] = ss_n;
      if (reset) begin
        last_rst = cyc;
        exp_dout = '0;
        tq.delete();
      end
      exp_busy = 1'b0;
      if ((cyc - S > last_rst) && (cyc - S >= 1) && (cyc - S < HN))
        exp_busy = !ss_hist[cyc-S];
      exp_tick = (tq.size() > 0) && (tq[0].cyc == cyc);
      chk("busy", busy, exp_busy);
      chk("miso_oe", miso_oe, exp_busy);
      chk("tick", spi_done_tick, exp_tick);
      if (exp_tick) begin
        exp_dout = tq[0].b;
        void'(tq.pop_front());
      end
      tick_next = (tq.size() > 0) && (tq[0].cyc == cyc + 1);
      if (!tick_next) chk("dout", dout, exp_dout);
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame(input logic pol, input logic pha, input logic [DW-1:0] d,
                             input bit chk_busy);
    m_pol = pol;
    m_pha = pha;
    cpol  = pol;
    cpha  = pha;
    sclk  = pol;
    din   = d;
    wait_neg(HP);
    ss_n = 1'b0;
    if (chk_busy) begin
      wait_neg(S);
      chk("busy_rise_early", busy, 1'b0);
      wait_neg(1);
      chk("busy_rise", busy, 1'b1);
      wait_neg(HP - S - 1);
    end else begin
      wait_neg(HP);
    end
    // mode pins move mid-frame; the captured mode must stay in force
    cpol = ~pol;
    cpha = ~pha;
  endtask

  task automatic end_frame(input bit chk_busy);
    ss_n = 1'b1;
    if (chk_busy) begin
      wait_neg(S);
      chk("busy_fall_early", busy, 1'b1);
      wait_neg(1);
      chk("busy_fall", busy, 1'b0);
      wait_neg(HP - S - 1);
    end else begin
      wait_neg(HP);
    end
  endtask

  task automatic send_byte(input logic [DW-1:0] mo, input int nbits, output logic [DW-1:0] got);
    logic b;
    exp_t e;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      b = mo[DW-1-i];
      if (!m_pha) begin
        mosi = b;
        wait_neg(Q);
        got  = {got[DW-2:0], miso};
        sclk = ~m_pol;
        if (i == DW - 1) begin
          e.cyc = cyc + S + 2;
          e.b   = mo;
          tq.push_back(e);
        end
        wait_neg(HP);
        sclk = m_pol;
        wait_neg(HP);
      end else begin
        sclk = ~m_pol;
        mosi = b;
        wait_neg(HP);
        got  = {got[DW-2:0], miso};
        sclk = m_pol;
        if (i == DW - 1) begin
          e.cyc = cyc + S + 2;
          e.b   = mo;
          tq.push_back(e);
        end
        wait_neg(HP);
      end
    end
  endtask

  initial begin
    logic [DW-1:0] got;
    reset = 1'b1;
    ss_n  = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    cpol  = 1'b0;
    cpha  = 1'b0;
    din   = '0;
    wait_neg(3);
    chk("rst_dout", dout, 8'h00);
    chk("rst_tick", spi_done_tick, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_miso", miso, 1'b0);
    chk("rst_miso_oe", miso_oe, 1'b0);
    reset = 1'b0;
    wait_neg(2);

    // mode 0
    start_frame(1'b0, 1'b0, 8'hA5, 1'b1);
    send_byte(8'h3C, 8, got);
    chk("m0_miso", got, 8'hA5);
    chk("m0_dout", dout, 8'h3C);
    end_frame(1'b1);

    // modes 1, 2, 3
    for (int m = 1; m < 4; m++) begin
      start_frame(m[1], m[0], 8'h81, 1'b0);
      send_byte(8'h7E, 8, got);
      chk($sformatf("m%0d_miso", m), got, 8'h81);
      chk($sformatf("m%0d_dout", m), dout, 8'h7E);
      end_frame(1'b0);
    end

    // two bytes in one frame, din updated before the byte boundary
    start_frame(1'b0, 1'b0, 8'h11, 1'b0);
    din = 8'h22;
    send_byte(8'hF0, 8, got);
    chk("bb1_miso", got, 8'h11);
    chk("bb1_dout", dout, 8'hF0);
    send_byte(8'h0F, 8, got);
    chk("bb2_miso", got, 8'h22);
    chk("bb2_dout", dout, 8'h0F);
    end_frame(1'b0);

    // frame aborted after 5 bits, then a full frame
    start_frame(1'b0, 1'b0, 8'h00, 1'b0);
    send_byte(8'hAA, 5, got);
    end_frame(1'b0);
    chk("abort_dout", dout, 8'h0F);
    chk("abort_busy", busy, 1'b0);
    start_frame(1'b0, 1'b0, 8'hC3, 1'b0);
    send_byte(8'h55, 8, got);
    chk("after_abort_miso", got, 8'hC3);
    chk("after_abort_dout", dout, 8'h55);
    end_frame(1'b0);

    // sclk activity with ss_n high
    chk("idle_miso_before", miso, 1'b1);
    for (int i = 0; i < 12; i++) begin
      sclk = ~sclk;
      wait_neg((i % 3) + 1);
    end
    sclk = 1'b0;
    wait_neg(HP);
    chk("glitch_dout", dout, 8'h55);
    chk("glitch_miso", miso, 1'b1);
    chk("glitch_busy", busy, 1'b0);

    // one-cycle reset in the middle of a byte
    start_frame(1'b0, 1'b0, 8'hFF, 1'b0);
    send_byte(8'h99, 4, got);
    reset = 1'b1;
    wait_neg(1);
    reset = 1'b0;
    ss_n  = 1'b1;
    chk("midrst_dout", dout, 8'h00);
    chk("midrst_tick", spi_done_tick, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_miso", miso, 1'b0);
    chk("midrst_miso_oe", miso_oe, 1'b0);
    wait_neg(2 * HP);

    // normal frame after the reset
    start_frame(1'b0, 1'b0, 8'h5A, 1'b0);
    send_byte(8'hE7, 8, got);
    chk("post_rst_miso", got, 8'h5A);
    chk("post_rst_dout", dout, 8'hE7);
    end_frame(1'b0);

    wait_neg(10);
    chk("ticks_outstanding", tq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
